// File: rtl/rf_multiport_regfile.sv
// Register file with one byte-enabled write port and NUM_RD registered read ports.
// An optional post-reset sweep zeroes every word before traffic is accepted.
module rf_multiport_regfile #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WORDS  = 1 << ADDR_WIDTH,
   parameter int NUM_RD     = 2,
   parameter bit BYPASS     = 1'b1,
   parameter bit INIT_ZERO  = 1'b1,
   localparam int BE_W      = DATA_WIDTH / 8
) (
   input  logic                           clock,
   input  logic                           reset,
   output logic                           init_done,
   input  logic                           wr_en,
   input  logic [ADDR_WIDTH-1:0]          wr_addr,
   input  logic [BE_W-1:0]                wr_be,
   input  logic [DATA_WIDTH-1:0]          data_in,
   input  logic [NUM_RD-1:0]              rd_en,
   input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0]   data_out,
   output logic [NUM_RD-1:0]              valid
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam logic [ADDR_WIDTH:0]   WORDS_W   = (ADDR_WIDTH + 1)'(NUM_WORDS);
   localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NUM_WORDS - 1);

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   init_cnt;
   logic [DATA_WIDTH-1:0]   mem [NUM_WORDS];
   logic                    wr_fire;
   logic [DATA_WIDTH-1:0]   wr_word;
   logic [DATA_WIDTH-1:0]   rd_word [NUM_RD];

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
      return {1'b0, addr} < WORDS_W;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] merge_bytes(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [BE_W-1:0]       be
   );
      logic [DATA_WIDTH-1:0] result;
      result = old_word;
      for (int b = 0; b < BE_W; b++)
         if (be[b]) result[8*b +: 8] = new_word[8*b +: 8];
      return result;
   endfunction

   assign wr_fire = (state == ST_RUN) && wr_en && in_range(wr_addr);

   // Out-of-range addresses read as zero and never touch storage.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      wr_word = '0;
      if (in_range(wr_addr))
         wr_word = merge_bytes(mem[wr_addr], data_in, wr_be);
      for (int p = 0; p < NUM_RD; p++) begin
         rd_word[p] = '0;
         if (in_range(rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
            if (BYPASS && wr_fire && (wr_addr == rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]))
               rd_word[p] = wr_word;
            else
               rd_word[p] = mem[rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
         end
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state     <= INIT_ZERO ? ST_INIT : ST_RUN;
         init_cnt  <= '0;
         init_done <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               init_cnt <= init_cnt + 1'b1;
               if (init_cnt == LAST_WORD) begin
                  state     <= ST_RUN;
                  init_done <= 1'b1;
               end
            end
            default: init_done <= 1'b1;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: the array itself is not reset; the zeroing sweep clears it so it stays RAM-mappable.
      if (!reset) begin
         if (state == ST_INIT)
            mem[init_cnt] <= '0;
         else if (wr_fire)
            mem[wr_addr] <= wr_word;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         data_out <= '0;
         valid    <= '0;
      end else if (state == ST_RUN) begin
         valid <= rd_en;
         for (int p = 0; p < NUM_RD; p++)
            if (rd_en[p]) data_out[p*DATA_WIDTH +: DATA_WIDTH] <= rd_word[p];
      end else begin
         valid <= '0;
      end
   end

endmodule

// File: tb/tb_rf_multiport_regfile.sv
// Randomised and directed bench for rf_multiport_regfile against a word-array reference model.
module tb_rf_multiport_regfile;

   logic        clock = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [3:0]  wr_be;
   logic [31:0] data_in;
   logic [1:0]  rd_en;
   logic [7:0]  rd_addr;

   logic        done [4];
   logic [63:0] dout [4];
   logic [1:0]  vld  [4];

   int errors = 0;
   int checks = 0;

   // Instance 0: bypass, 1: no bypass, 2: 12 words, 3: no zeroing sweep.
   int NW  [4] = '{16, 16, 12, 16};
   bit BYP [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
   bit IZ  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

   logic [31:0] m_mem  [4][16];
   int          m_cyc  [4];
   logic [63:0] e_dout [4];
   logic [1:0]  e_vld  [4];
   logic        e_done [4];

   always #5 clock = ~clock;

   rf_multiport_regfile #(.BYPASS(1'b1)) u_dut0 (
      .clock(clock), .reset(reset), .init_done(done[0]), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_be(wr_be), .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr),
      .data_out(dout[0]), .valid(vld[0]));
   rf_multiport_regfile #(.BYPASS(1'b0)) u_dut1 (
      .clock(clock), .reset(reset), .init_done(done[1]), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_be(wr_be), .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr),
      .data_out(dout[1]), .valid(vld[1]));
   rf_multiport_regfile #(.NUM_WORDS(12)) u_dut2 (
      .clock(clock), .reset(reset), .init_done(done[2]), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_be(wr_be), .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr),
      .data_out(dout[2]), .valid(vld[2]));
   rf_multiport_regfile #(.INIT_ZERO(1'b0)) u_dut3 (
      .clock(clock), .reset(reset), .init_done(done[3]), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_be(wr_be), .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr),
      .data_out(dout[3]), .valid(vld[3]));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] merged(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
      logic [31:0] r;
      for (int b = 0; b < 4; b++)
         r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
      return r;
   endfunction

   // Advance the model by one edge using the inputs currently applied.
   task automatic model_edge();
      for (int i = 0; i < 4; i++) begin
         if (reset) begin
            e_dout[i] = '0;
            e_vld[i]  = '0;
            e_done[i] = 1'b0;
            m_cyc[i]  = 0;
            for (int a = 0; a < 16; a++) m_mem[i][a] = '0;
         end else begin
            if (!IZ[i] || m_cyc[i] >= NW[i]) begin
               for (int p = 0; p < 2; p++) begin
                  if (rd_en[p]) begin
                     int a;
                     logic [31:0] w;
                     a = int'(rd_addr[p*4 +: 4]);
                     w = (a < NW[i]) ? m_mem[i][a] : 32'h0;
                     if (BYP[i] && wr_en && a < NW[i] && int'(wr_addr) == a)
                        w = merged(w, data_in, wr_be);
                     e_dout[i][p*32 +: 32] = w;
                  end
               end
               e_vld[i] = rd_en;
               if (wr_en && int'(wr_addr) < NW[i])
                  m_mem[i][wr_addr] = merged(m_mem[i][wr_addr], data_in, wr_be);
            end else begin
               e_vld[i] = '0;
            end
            if (m_cyc[i] < 1000) m_cyc[i]++;
            e_done[i] = IZ[i] ? (m_cyc[i] >= NW[i]) : 1'b1;
         end
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clock);
      #1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("dut%0d init_done", i), 64'(done[i]), 64'(e_done[i]));
         check($sformatf("dut%0d valid", i), 64'(vld[i]), 64'(e_vld[i]));
         if (IZ[i]) check($sformatf("dut%0d data_out", i), dout[i], e_dout[i]);
      end
   endtask

   task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input logic [1:0] re, input logic [3:0] ra0,
                        input logic [3:0] ra1);
      wr_en   = we;
      wr_addr = wa;
      data_in = wd;
      wr_be   = be;
      rd_en   = re;
      rd_addr = {ra1, ra0};
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 4'd0, 32'h0, 4'h0, 2'b00, 4'd0, 4'd0);
      step();
      step();
      reset = 1'b0;

      // Sweep timing, then every word reads zero.
      repeat (15) step();
      check("t1 done before 16", 64'(done[0]), 64'd0);
      step();
      check("t1 done at 16", 64'(done[0]), 64'd1);
      for (int a = 0; a < 16; a++) begin
         drive(1'b0, 4'd0, 32'h0, 4'h0, 2'b11, 4'(a), 4'(15 - a));
         step();
      end
      check("t1 zero word", dout[0], 64'h0);

      // Full write then dual-port read.
      drive(1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 2'b00, 4'd0, 4'd0);
      step();
      drive(1'b0, 4'd0, 32'h0, 4'h0, 2'b11, 4'd3, 4'd3);
      step();
      check("t2 data both ports", dout[0], 64'hDEADBEEF_DEADBEEF);
      check("t2 valid", 64'(vld[0]), 64'd3);

      // Partial write colliding with a read.
      drive(1'b1, 4'd3, 32'h11223344, 4'b0101, 2'b01, 4'd3, 4'd0);
      step();
      check("t3 bypass", 64'(dout[0][31:0]), 64'hDE22BE44);
      check("t3 no bypass", 64'(dout[1][31:0]), 64'hDEADBEEF);
      drive(1'b0, 4'd0, 32'h0, 4'h0, 2'b01, 4'd3, 4'd0);
      step();
      check("t3 later read nb", 64'(dout[1][31:0]), 64'hDE22BE44);

      // Valid drops while data holds.
      drive(1'b0, 4'd0, 32'h0, 4'h0, 2'b00, 4'd0, 4'd0);
      step();
      check("t4 valid low", 64'(vld[0]), 64'd0);
      check("t4 data held", 64'(dout[0][31:0]), 64'hDE22BE44);

      // Reset in the middle of a sweep.
      drive(1'b1, 4'd2, 32'h55, 4'hF, 2'b00, 4'd0, 4'd0);
      step();
      reset = 1'b1;
      drive(1'b0, 4'd0, 32'h0, 4'h0, 2'b00, 4'd0, 4'd0);
      step();
      reset = 1'b0;
      repeat (7) step();
      reset = 1'b1;
      drive(1'b1, 4'd2, 32'h55, 4'hF, 2'b11, 4'd2, 4'd2);
      step();
      reset = 1'b0;
      repeat (15) step();
      check("t5 done waits", 64'(done[0]), 64'd0);
      step();
      check("t5 done after 16", 64'(done[0]), 64'd1);
      drive(1'b0, 4'd0, 32'h0, 4'h0, 2'b01, 4'd2, 4'd0);
      step();
      check("t5 addr2 cleared", 64'(dout[0][31:0]), 64'h0);

      // Out-of-range access on the 12-word array.
      drive(1'b1, 4'd14, 32'hA5A5A5A5, 4'hF, 2'b00, 4'd0, 4'd0);
      step();
      drive(1'b0, 4'd0, 32'h0, 4'h0, 2'b11, 4'd14, 4'd11);
      step();
      check("t6 oor read zero", 64'(dout[2][31:0]), 64'h0);
      check("t6 oor valid", 64'(vld[2]), 64'd3);
      for (int a = 0; a < 12; a += 2) begin
         drive(1'b0, 4'd0, 32'h0, 4'h0, 2'b11, 4'(a), 4'(a + 1));
         step();
      end

      // Random traffic with frequent collisions and occasional resets.
      for (int n = 0; n < 800; n++) begin
         logic [3:0] wa;
         wa    = 4'($urandom_range(0, 15));
         reset = ($urandom_range(0, 199) == 0);
         drive(1'($urandom), wa, $urandom, 4'($urandom), 2'($urandom),
               ($urandom_range(0, 2) == 0) ? wa : 4'($urandom),
               ($urandom_range(0, 2) == 0) ? wa : 4'($urandom));
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
